// File: rtl/gcd_pkg.sv
// Shared definitions for the gcd -> lcm pipeline: LCM FSM states, default
// operand width and step-counter sizing.
package gcd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        MUL  = 2'd2,
        DONE = 2'd3
    } lcm_state_t;

    localparam int GCD_W = 8;

    // Counter must be able to hold the step count W itself.
    function automatic int step_cnt_w(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/lcm_div_step.sv
// One combinational restoring-division step: shift in the next dividend bit,
// subtract the divisor when it fits and emit the quotient bit.
module lcm_div_step
    import gcd_pkg::*;
#(
    parameter int W = GCD_W
) (
    input  logic [W-1:0] i_rem,
    input  logic         i_bit,
    input  logic [W-1:0] i_div,
    output logic [W-1:0] o_rem,
    output logic         o_q
);

    logic [W:0] w_shift;

    assign w_shift = {i_rem, i_bit};
    assign o_q     = (w_shift >= {1'b0, i_div});
    // The incoming remainder is below the divisor, so the difference fits in W bits.
    assign o_rem   = o_q ? W'(w_shift - {1'b0, i_div}) : w_shift[W-1:0];

endmodule

// File: rtl/lcm_calc.sv
// Serial LCM stage: lcm = (data_a / gcd) * data_b via an 8-step restoring divider
// followed by an 8-step shift-add multiplier. Optional LCM_CHECK_EN adds the err path.
module lcm_calc
    import gcd_pkg::*;
#(
    parameter int W = GCD_W
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           clk_en,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   data_a,
    input  logic [W-1:0]   data_b,
    input  logic [W-1:0]   gcd,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] lcm,
    output logic           err
);

    localparam int              CNT_W = step_cnt_w(W);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(W - 1);

    lcm_state_t       r_state;
    lcm_state_t       w_next;
    logic [W-1:0]     r_a;
    logic [2*W-1:0]   r_bsh;
    logic [W-1:0]     r_g;
    logic [W-1:0]     r_q;
    logic [W-1:0]     r_rem;
    logic [CNT_W-1:0] r_cnt;
    logic [2*W-1:0]   r_acc;
    logic [2*W-1:0]   r_lcm;

    logic             w_zero_op;
    logic             w_zero_g;
    logic             w_last;
    logic [W-1:0]     w_div_rem;
    logic             w_div_q;
    logic [2*W-1:0]   w_acc_nx;

    assign w_zero_op = (data_a == '0) || (data_b == '0);
    assign w_zero_g  = (gcd == '0);
    assign w_last    = (r_cnt == LAST);
    assign w_acc_nx  = r_acc + (r_q[0] ? r_bsh : '0);

    lcm_div_step #(.W(W)) u_div_step (
        .i_rem (r_rem),
        .i_bit (r_a[W-1]),
        .i_div (r_g),
        .o_rem (w_div_rem),
        .o_q   (w_div_q)
    );

    // NOTE: sequential state uses <= so every register updates from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else if (clk_en) begin
            r_state <= w_next;
        end
    end

    // NOTE: every always_comb output gets a default first, so no latch is inferred.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (in_valid) w_next = (w_zero_op || w_zero_g) ? DONE : DIV;
            DIV:     if (w_last) w_next = MUL;
            MUL:     if (w_last) w_next = DONE;
            DONE:    if (out_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            IDLE:    in_ready  = 1'b1;
            DONE:    out_valid = 1'b1;
            default: ;
        endcase
    end

`ifdef LCM_CHECK_EN
    logic r_err;
    assign err = r_err;
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a   <= '0;
            r_bsh <= '0;
            r_g   <= '0;
            r_q   <= '0;
            r_rem <= '0;
            r_cnt <= '0;
            r_acc <= '0;
            r_lcm <= '0;
`ifdef LCM_CHECK_EN
            r_err <= 1'b0;
`endif
        end else if (clk_en) begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a   <= data_a;
                        r_bsh <= {{W{1'b0}}, data_b};
                        r_g   <= gcd;
                        r_q   <= '0;
                        r_rem <= '0;
                        r_cnt <= '0;
                        r_acc <= '0;
                        r_lcm <= '0;
`ifdef LCM_CHECK_EN
                        r_err <= !w_zero_op && w_zero_g;
`endif
                    end
                end
                DIV: begin
                    r_a   <= r_a << 1;
                    r_rem <= w_div_rem;
                    r_q   <= {r_q[W-2:0], w_div_q};
                    r_cnt <= w_last ? '0 : r_cnt + 1'b1;
                end
                MUL: begin
                    r_acc <= w_acc_nx;
                    r_bsh <= r_bsh << 1;
                    r_q   <= r_q >> 1;
                    r_cnt <= w_last ? '0 : r_cnt + 1'b1;
                    if (w_last) begin
`ifdef LCM_CHECK_EN
                        // A leftover remainder means g does not divide a.
                        if (r_rem != '0) begin
                            r_lcm <= '0;
                            r_err <= 1'b1;
                        end else begin
                            r_lcm <= w_acc_nx;
                        end
`else
                        r_lcm <= w_acc_nx;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    assign lcm = r_lcm;

endmodule
